seq_logic_unit: RTL and testbench

//  Multi-cycle, parametrised bitwise logic unit for the ALU datapath.
//  It replaces fixed 32-bit single-op gate arrays with one block that supports WIDTH bits and four ops.

---
 rtl/seq_logic_unit.sv | 151 +++++++++++++++
 tb/tb_seq_logic_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_logic_unit
//  Description : Multi-cycle bitwise logic unit (AND/OR/XOR/NOR) that walks
//                latched operands SLICE bits per clock; start/busy/done
//                handshake with a registered zero flag.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int            c_NSLICE = WIDTH / SLICE;
    localparam int            c_CW     = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam int            c_BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NSLICE - 1);

    localparam logic [1:0] c_OP_AND = 2'b00;
    localparam logic [1:0] c_OP_OR  = 2'b01;
    localparam logic [1:0] c_OP_XOR = 2'b10;

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("seq_logic_unit: SLICE must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;

    logic              w_accept;
    logic              w_last;
    logic [c_BW-1:0]   w_base;
    logic [SLICE-1:0]  w_a_slice;
    logic [SLICE-1:0]  w_b_slice;
    logic [SLICE-1:0]  w_slice;
    logic [WIDTH-1:0]  w_next_result;

    // A new request is taken whenever the unit is not mid-operation, which
    // makes DONE -> RUN back-to-back behave exactly like IDLE -> RUN.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == c_LAST);
    assign w_base   = c_BW'(r_cnt) * c_BW'(SLICE);

    assign w_a_slice = r_a[w_base +: SLICE];
    assign w_b_slice = r_b[w_base +: SLICE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_slice = '0;
        case (r_op)
            c_OP_AND: w_slice = w_a_slice & w_b_slice;
            c_OP_OR:  w_slice = w_a_slice | w_b_slice;
            c_OP_XOR: w_slice = w_a_slice ^ w_b_slice;
            default:  w_slice = ~(w_a_slice | w_b_slice);
        endcase
    end

    // Full-width view of the result after this cycle's slice lands, so the
    // zero flag on the final edge sees the slice being written.
    always_comb begin
        w_next_result                  = r_result;
        w_next_result[w_base +: SLICE] = w_slice;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a    <= input1;
            r_b    <= input2;
            r_op   <= op;
            r_cnt  <= '0;
            r_zero <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_result <= w_next_result;
            if (w_last) begin
                r_zero <= (w_next_result == '0);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign result = r_result;
    assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_logic_unit
//  Description : Randomised scoreboard bench for seq_logic_unit (32/8 main
//                instance plus (32,32), (64,16), (8,1) sweep instances).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_logic_unit;

    localparam int W0 = 32;
    localparam int S0 = 8;
    localparam int N0 = W0 / S0;

    typedef struct {
        logic [63:0] res;
        logic        zero;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_sw_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   sw_fin = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: whole-word bitwise operation, masked to the instance width.
    function automatic exp_t mk_exp(input logic [1:0] o, input logic [63:0] a,
                                    input logic [63:0] b, input int w, input int t);
        exp_t        e;
        logic [63:0] m;
        logic [63:0] r;
        m = '1;
        if (w < 64) m = (64'd1 << w) - 64'd1;
        case (o)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = ~(a | b);
        endcase
        e.res  = r & m;
        e.zero = (e.res == 64'd0);
        e.t    = t;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- main 32/8 instance ----------------
    logic          start0;
    logic [1:0]    op0;
    logic [W0-1:0] in1_0, in2_0, result0;
    logic          busy0, done0, zero0;
    exp_t          q0[$];
    int            free0 = 0;

    seq_logic_unit #(.WIDTH(W0), .SLICE(S0)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start0),
        .op     (op0),
        .input1 (in1_0),
        .input2 (in2_0),
        .busy   (busy0),
        .done   (done0),
        .result (result0),
        .zero   (zero0)
    );

    // One clock of stimulus, entered and left at a falling edge. Acceptance is
    // predicted from timing alone: an op accepted at edge e frees the unit at
    // edge e+N0+1.
    task automatic step(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
        start0 = s;
        op0    = o;
        in1_0  = a;
        in2_0  = b;
        if (s && (cyc + 1 >= free0)) begin
            q0.push_back(mk_exp(o, 64'(a), 64'(b), W0, cyc));
            free0 = cyc + 1 + N0 + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'($urandom), $urandom, $urandom, 1'b0);
    endtask

    task automatic wait_free();
        for (int i = 0; i < 100 && (cyc + 1 < free0); i++)
            step(2'($urandom), $urandom, $urandom, 1'b0);
    endtask

    int   run0 = 0;
    logic pd0  = 1'b0;
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst_n) begin
            run0 = 0;
            pd0  = 1'b0;
        end else begin
            if (done0) begin
                chk("done_single_pulse", 64'(pd0), 64'd0);
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got result %0h expected no done", result0);
                end else begin
                    e = q0.pop_front();
                    chk("result", 64'(result0), e.res);
                    chk("zero", 64'(zero0), 64'(e.zero));
                    chk("done_latency", 64'(cyc - e.t), 64'(N0 + 1));
                    chk("busy_cycles", 64'(run0), 64'(N0));
                end
                run0 = 0;
            end
            if (busy0) run0++;
            pd0 = done0;
        end
    end

    // ---------------- parameter sweep instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W = (g == 0) ? 32 : (g == 1) ? 64 : 8;
        localparam int S = (g == 0) ? 32 : (g == 1) ? 16 : 1;
        localparam int N = W / S;

        logic         st;
        logic [1:0]   o;
        logic [W-1:0] a, b, res;
        logic         bz, dn, zr;
        exp_t         q[$];
        int           free_at = 0;
        int           run = 0;

        seq_logic_unit #(.WIDTH(W), .SLICE(S)) u_dut (
            .clk    (clk),
            .rst_n  (rst_sw_n),
            .start  (st),
            .op     (o),
            .input1 (a),
            .input2 (b),
            .busy   (bz),
            .done   (dn),
            .result (res),
            .zero   (zr)
        );

        initial begin : drv
            logic [63:0] ra, rb;
            st = 1'b0;
            o  = 2'd0;
            a  = '0;
            b  = '0;
            @(posedge rst_sw_n);
            @(negedge clk);
            for (int i = 0; i < 200; i++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if ($urandom_range(3) == 0) rb = ra;
                st = ($urandom_range(1) == 1);
                o  = 2'($urandom);
                a  = W'(ra);
                b  = W'(rb);
                if (st && (cyc + 1 >= free_at)) begin
                    q.push_back(mk_exp(o, 64'(a), 64'(b), W, cyc));
                    free_at = cyc + 1 + N + 1;
                end
                @(negedge clk);
            end
            st = 1'b0;
            repeat (N + 3) @(negedge clk);
            chk($sformatf("sw%0d_drained", g), 64'(q.size()), 64'd0);
            sw_fin++;
        end

        always @(negedge clk) begin : mon
            exp_t e;
            if (!rst_sw_n) begin
                run = 0;
            end else begin
                if (dn) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sw%0d_unexpected_done got result %0h expected no done", g, res);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("sw%0d_result", g), 64'(res), e.res);
                        chk($sformatf("sw%0d_zero", g), 64'(zr), 64'(e.zero));
                        chk($sformatf("sw%0d_latency", g), 64'(cyc - e.t), 64'(N + 1));
                        chk($sformatf("sw%0d_busy_cycles", g), 64'(run), 64'(N));
                    end
                    run = 0;
                end
                if (bz) run++;
            end
        end
    end

    // ---------------- directed + random sequence on main instance ----------------
    initial begin : main_seq
        rst_n    = 1'b0;
        rst_sw_n = 1'b0;
        start0   = 1'b0;
        op0      = 2'd0;
        in1_0    = '0;
        in2_0    = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_done", 64'(done0), 64'd0);
        chk("reset_result", 64'(result0), 64'd0);
        chk("reset_zero", 64'(zero0), 64'd0);
        rst_n    = 1'b1;
        rst_sw_n = 1'b1;
        idle(1);

        step(2'd1, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1);
        wait_free();
        idle(2);

        step(2'd0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
        wait_free();
        step(2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        wait_free();
        idle(1);

        // Operand and op lines churn while the unit is running.
        step(2'd3, 32'h0000_0000, 32'h0000_00FF, 1'b1);
        wait_free();
        idle(1);

        // Starts during RUN are dropped; the start in the done cycle is taken.
        step(2'd1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
        step(2'd2, 32'hCAFE_F00D, 32'h1111_2222, 1'b1);
        step(2'd0, 32'h0BAD_0BAD, 32'h7777_7777, 1'b1);
        wait_free();
        step(2'd0, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1);
        wait_free();
        idle(2);

        // Reset aborts an operation in its second RUN cycle.
        step(2'd1, 32'h0000_00A5, 32'h5A00_0000, 1'b1);
        step(2'd0, 32'h0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy0), 64'd0);
        chk("abort_done", 64'(done0), 64'd0);
        chk("abort_result", 64'(result0), 64'd0);
        chk("abort_zero", 64'(zero0), 64'd0);
        q0.delete();
        free0 = 0;
        start0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b0;
        rst_n  = 1'b1;
        idle(1);
        step(2'd1, 32'h8000_0001, 32'h0000_1000, 1'b1);
        wait_free();
        idle(3);
        chk("hold_after_idle", 64'(result0), 64'h8000_1001);

        for (int i = 0; i < 120; i++)
            step(2'($urandom), $urandom, ($urandom_range(3) == 0) ? 32'h0 : $urandom,
                 1'($urandom_range(1)));
        start0 = 1'b0;
        wait_free();
        idle(3);
        chk("main_drained", 64'(q0.size()), 64'd0);

        for (int i = 0; i < 2000 && sw_fin < 3; i++) @(negedge clk);
        if (sw_fin < 3) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout got %0d finished expected 3", sw_fin);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
